peripheral_arbiter_apb4: RTL and testbench
==========================================

Name: peripheral_arbiter_apb4

Overview:
Round-robin arbiter and sequencer that shares one APB4 master port between NUM_REQ independent requesters, for example the CPU bridge, the DMA and the debug unit.
Each requester posts a single read or write command. The block grants one requester at a time, drives the full APB4 SETUP/ACCESS protocol, waits on PREADY, and returns the read data and the error status to that requester only.
It sits between the requesters and the UART/GPIO APB4 slave fabric.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
PADDR_SIZE, 16, APB address width
PDATA_SIZE, 32, APB data width (multiple of 8)

Ports:
PCLK  input  1  bus clock; all state updates on the rising edge
PRESET  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester command pending; held high until the matching ack
req_write  input  NUM_REQ  per-requester direction; 1 = write
req_addr  input  NUM_REQ*PADDR_SIZE  packed addresses; requester i uses slice [i*PADDR_SIZE +: PADDR_SIZE]
req_wdata  input  NUM_REQ*PDATA_SIZE  packed write data
req_strb  input  NUM_REQ*PDATA_SIZE/8  packed byte strobes
req_ack  output  NUM_REQ  one-hot, one-cycle completion pulse
req_rdata  output  PDATA_SIZE  captured PRDATA; valid while req_ack is nonzero
req_slverr  output  1  captured PSLVERR; valid while req_ack is nonzero
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  PADDR_SIZE  APB address
PWRITE  output  1  APB direction
PWDATA  output  PDATA_SIZE  APB write data
PSTRB  output  PDATA_SIZE/8  APB strobes
PRDATA  input  PDATA_SIZE  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB slave error

Behaviour:
- All outputs are registered.
- Reset values:
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA, PSTRB = 0.
  - req_ack = 0, req_rdata = 0, req_slverr = 0.
  - FSM = IDLE.
  - last-grant pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise pick the first requester with req_valid high, scanning from (last+1) mod NUM_REQ upward with wrap-around. Latch its index as grant.
  - Load PADDR, PWRITE, PWDATA and PSTRB from its slices. For reads, PWDATA = 0 and PSTRB = 0.
  - Set PSEL = 1 and go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE = 1 and go to ACCESS.
- ACCESS:
  - While PREADY = 0, hold every APB output stable.
  - On a rising edge with PREADY = 1: capture PRDATA into req_rdata and PSLVERR into req_slverr.
  - In the same edge: set PSEL = 0, PENABLE = 0, req_ack[grant] = 1, last = grant, and go to DONE.
- DONE:
  - Lasts one cycle. req_ack clears on the next edge; state returns to IDLE.
  - req_valid is not sampled in DONE, so the acknowledged requester has one cycle to drop req_valid.
- PADDR, PWDATA, PSTRB and PWRITE hold their last values outside transfers.
- req_rdata and req_slverr hold until the next completion.
- Latency:
  - req_valid high before edge k gives PSEL = 1 after edge k and PENABLE = 1 after edge k+1.
  - With zero wait states, ack is high after edge k+2.
  - Back-to-back transfers take 4 cycles each: IDLE, SETUP, ACCESS, DONE.
- Requester fields are sampled only in IDLE.
  - Changes while granted are ignored.
  - Deasserting req_valid mid-transfer does not abort the transfer; ack is still issued.
- Simultaneous requests are resolved only by the rotating priority. A requester that has just been served has the lowest priority next time.
- No timeout: the FSM waits in ACCESS indefinitely.
- PSLVERR is only meaningful with PREADY. It is captured on the completing edge and ignored during wait states.
- Asserting PRESET at any point, including mid-ACCESS, immediately forces the reset values.
  - The interrupted transfer is not acknowledged.
  - After PRESET is released, arbitration restarts with requester 0 first.

Test Plan:
1. Single write, zero wait: req_valid[0] = 1, addr 0x0010, wdata 0xA5A5_0001, strb 0xF.
   → PSEL for 2 cycles, PENABLE in the second, PWRITE = 1, correct PADDR/PWDATA/PSTRB; req_ack = 3'b001 for one cycle 3 edges after request.
2. Read with 3 wait states: requester 1 reads 0x0004; slave drives PREADY low 3 cycles, then high with PRDATA = 0x1234_5678.
   → APB outputs stable throughout ACCESS; PSTRB = 0; req_ack = 3'b010; req_rdata = 0x1234_5678; req_slverr = 0.
3. Round-robin fairness: all three req_valid held high and re-asserted after each ack.
   → grant order 0,1,2,0,1,2; each transfer occupies 4 cycles; no requester is served twice in a row.
4. Slave error: requester 2 writes, slave returns PREADY = 1 with PSLVERR = 1.
   → req_ack = 3'b100 and req_slverr = 1. Next transfer with PSLVERR = 0 → req_slverr = 0.
5. Reset mid-transfer: assert PRESET while in ACCESS with PREADY low.
   → PSEL = PENABLE = 0 asynchronously, no ack. After release with requesters 1 and 2 pending → requester 1 is granted first.
6. Late field change: requester 0 changes req_addr during SETUP.
   → PADDR keeps the value sampled in IDLE for the whole transfer.

Source files
------------

// File: rtl/peripheral_arbiter_apb4.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_arbiter_apb4
//  Purpose  : Round-robin arbiter/sequencer sharing one APB4 master port
//             between NUM_REQ requesters. The winner's command is latched,
//             played out as a SETUP/ACCESS transfer, and the read data and
//             error status are returned with a one-hot, one-cycle ack.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    PCLK, PRESET  : bus clock; asynchronous active-high reset
//    req_valid     : per-requester command pending (held until its ack)
//    req_write     : per-requester direction, 1 = write
//    req_addr      : packed addresses, slice [i*PADDR_SIZE +: PADDR_SIZE]
//    req_wdata     : packed write data, slice [i*PDATA_SIZE +: PDATA_SIZE]
//    req_strb      : packed byte strobes, slice [i*PDATA_SIZE/8 +: PDATA_SIZE/8]
//    req_ack       : one-hot completion pulse, one cycle wide
//    req_rdata     : PRDATA captured on the completing edge
//    req_slverr    : PSLVERR captured on the completing edge
//    PSEL..PSTRB   : APB4 master outputs (all registered)
//    PRDATA, PREADY, PSLVERR : APB4 slave responses
// ============================================================================
module peripheral_arbiter_apb4 #(
    parameter int NUM_REQ    = 3,
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*PADDR_SIZE-1:0]    req_addr,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]    req_wdata,
    input  logic [NUM_REQ*PDATA_SIZE/8-1:0]  req_strb,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [PDATA_SIZE-1:0]            req_rdata,
    output logic                             req_slverr,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic [PADDR_SIZE-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [PDATA_SIZE-1:0]            PWDATA,
    output logic [PDATA_SIZE/8-1:0]          PSTRB,
    input  logic [PDATA_SIZE-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_SW = PDATA_SIZE / 8;

    // Index arithmetic is one bit wider than a grant index so that
    // last+1 and start+offset can exceed NUM_REQ-1 before wrapping.
    localparam logic [c_GW:0]        c_NUM     = (c_GW+1)'(NUM_REQ);
    localparam logic [c_GW:0]        c_ONE_W   = (c_GW+1)'(1);
    localparam logic [c_GW-1:0]      c_LAST_RST = c_GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   c_ACK_ONE = NUM_REQ'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]          r_state;
    logic [c_GW-1:0]     r_grant;
    logic [c_GW-1:0]     r_last;

    // Per-requester views of the packed command buses.
    logic [PADDR_SIZE-1:0] w_addr  [NUM_REQ];
    logic [PDATA_SIZE-1:0] w_wdata [NUM_REQ];
    logic [c_SW-1:0]       w_strb  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_addr[i]  = req_addr[i*PADDR_SIZE +: PADDR_SIZE];
        assign w_wdata[i] = req_wdata[i*PDATA_SIZE +: PDATA_SIZE];
        assign w_strb[i]  = req_strb[i*c_SW +: c_SW];
    end

    // ------------------------------------------------------------------
    // Rotating-priority pick. The valid vector is doubled and a window of
    // NUM_REQ bits starting at last+1 is taken, so bit 0 of the window is
    // the highest-priority requester. The lowest set bit of the window is
    // the offset from last+1 to the winner.
    // ------------------------------------------------------------------
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [c_GW:0]        w_start;
    logic [c_GW:0]        w_off;
    logic [c_GW:0]        w_sum;
    logic [c_GW-1:0]      w_sel;
    logic                 w_found;

    always_comb begin
        w_start = {1'b0, r_last} + c_ONE_W;
        if (w_start == c_NUM) begin
            w_start = '0;
        end
        w_dbl   = {req_valid, req_valid};
        w_rot   = w_dbl[w_start +: NUM_REQ];
        w_found = |w_rot;
        w_off   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = (c_GW+1)'(j);
            end
        end
        w_sum = w_start + w_off;
        if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
        end
        w_sel = w_sum[c_GW-1:0];
    end

    // ------------------------------------------------------------------
    // Transfer sequencer. Every output is a flop; address/data/strobe
    // flops are only loaded in IDLE so they hold between transfers.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= c_IDLE;
            r_grant    <= '0;
            r_last     <= c_LAST_RST;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSTRB      <= '0;
            req_ack    <= '0;
            req_rdata  <= '0;
            req_slverr <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        PADDR   <= w_addr[w_sel];
                        PWRITE  <= req_write[w_sel];
                        // Reads drive zero data and zero strobes.
                        PWDATA  <= req_write[w_sel] ? w_wdata[w_sel] : '0;
                        PSTRB   <= req_write[w_sel] ? w_strb[w_sel]  : '0;
                        PSEL    <= 1'b1;
                        r_state <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= c_ACCESS;
                end
                c_ACCESS: begin
                    // PSLVERR and PRDATA are only meaningful with PREADY.
                    if (PREADY) begin
                        req_rdata  <= PRDATA;
                        req_slverr <= PSLVERR;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        req_ack    <= c_ACK_ONE << r_grant;
                        r_last     <= r_grant;
                        r_state    <= c_DONE;
                    end
                end
                c_DONE: begin
                    // req_valid is ignored here so the served requester
                    // has a cycle to drop its request.
                    req_ack <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_arbiter_apb4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peripheral_arbiter_apb4
//  Purpose  : Self-checking bench for peripheral_arbiter_apb4. A simple APB
//             slave responds with programmable wait states; expected grants
//             come from a rotating-priority model over the request mask.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_arbiter_apb4;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_strb;
    logic [N-1:0]      req_ack;
    logic [DW-1:0]     req_rdata;
    logic              req_slverr;
    logic              PSEL;
    logic              PENABLE;
    logic [AW-1:0]     PADDR;
    logic              PWRITE;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int n_vec = 0;
    int n_bad = 0;
    int m_last;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } fld_t;

    typedef struct packed {
        bit            proto;
        bit            stable;
        fld_t          f;
        logic [N-1:0]  ack;
        logic [DW-1:0] rdata;
        logic          err;
        logic [7:0]    ack_n;
        logic [7:0]    cycles;
    } obs_t;

    peripheral_arbiter_apb4 #(.NUM_REQ(N), .PADDR_SIZE(AW), .PDATA_SIZE(DW)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_ack(req_ack), .req_rdata(req_rdata), .req_slverr(req_slverr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Winner is the first pending requester after the last one served.
    function automatic int model_pick(input logic [N-1:0] m);
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (m_last + off) % N;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic fld_t model_fields(input int g);
        fld_t f;
        f.addr  = req_addr[g*AW +: AW];
        f.wr    = req_write[g];
        f.wdata = f.wr ? req_wdata[g*DW +: DW] : '0;
        f.strb  = f.wr ? req_strb[g*SW +: SW]  : '0;
        return f;
    endfunction

    task automatic scramble_fields();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = AW'($urandom);
            req_wdata[i*DW +: DW] = $urandom;
            req_strb[i*SW +: SW]  = SW'($urandom);
        end
        req_write = N'($urandom);
    endtask

    // ---------------- APB slave / observer ----------------
    // Called with the DUT idle and requests already presented. Records what
    // the DUT drove; all judgements are made by the calling test.
    task automatic run_xfer(input int waits, input logic [DW-1:0] rd,
                            input logic err, input bit drop, output obs_t o);
        int n;
        n = 0;
        o = '0;
        o.proto  = 1'b1;
        o.stable = 1'b1;
        PREADY  = 1'b0;
        do begin
            @(posedge PCLK); #1; n++;
        end while (!PSEL && n < 16);
        if (!PSEL) begin
            o.proto = 1'b0;
            return;
        end
        if (PENABLE || req_ack != '0) o.proto = 1'b0;
        o.f = {PADDR, PWRITE, PWDATA, PSTRB};
        // Requester fields change during SETUP; the transfer must not see it.
        scramble_fields();
        if (drop) req_valid = '0;
        @(posedge PCLK); #1; n++;
        if (!(PSEL && PENABLE)) o.proto = 1'b0;
        if ({PADDR, PWRITE, PWDATA, PSTRB} !== o.f) o.stable = 1'b0;
        for (int w = 0; w < waits; w++) begin
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
            @(posedge PCLK); #1; n++;
            if (!(PSEL && PENABLE) || req_ack != '0) o.stable = 1'b0;
            if ({PADDR, PWRITE, PWDATA, PSTRB} !== o.f) o.stable = 1'b0;
        end
        PREADY  = 1'b1;
        PRDATA  = rd;
        PSLVERR = err;
        @(posedge PCLK); #1; n++;
        o.ack   = req_ack;
        o.rdata = req_rdata;
        o.err   = req_slverr;
        o.ack_n = 8'(n);
        if (PSEL || PENABLE) o.proto = 1'b0;
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'b0;
        @(posedge PCLK); #1; n++;
        if (req_ack != '0 || PSEL) o.proto = 1'b0;
        if (req_rdata !== rd || req_slverr !== err) o.stable = 1'b0;
        o.cycles = 8'(n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        PRESET = 1'b1;
        req_valid = '1;
        scramble_fields();
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        n_vec++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 000", {PSEL, PENABLE, PWRITE});
        end
        n_vec++;
        if ({PADDR, PWDATA, PSTRB} !== '0) begin
            n_bad++; $display("FAIL reset_bus: got %h/%h/%h want 0", PADDR, PWDATA, PSTRB);
        end
        n_vec++;
        if ({req_ack, req_rdata, req_slverr} !== '0) begin
            n_bad++; $display("FAIL reset_resp: got %b/%h/%b want 0", req_ack, req_rdata, req_slverr);
        end
        req_valid = '0;
        PRESET = 1'b0;
        m_last = N - 1;
        repeat (2) @(posedge PCLK);
        #1;
        n_vec++;
        if (PSEL !== 1'b0) begin
            n_bad++; $display("FAIL idle_no_req: PSEL got %b want 0", PSEL);
        end
    endtask

    task automatic test_single_write();
        obs_t o; fld_t f; int g; logic [N-1:0] ea;
        req_addr[AW-1:0]  = 16'h0010;
        req_wdata[DW-1:0] = 32'hA5A5_0001;
        req_strb[SW-1:0]  = 4'hF;
        req_write[0]      = 1'b1;
        req_valid         = 3'b001;
        g = model_pick(req_valid); f = model_fields(g); ea = N'(1) << g;
        run_xfer(0, 32'hDEAD_BEEF, 1'b0, 1'b0, o);
        req_valid = '0; m_last = g;
        n_vec++;
        if (o.proto !== 1'b1) begin n_bad++; $display("FAIL wr_protocol: got %b want 1", o.proto); end
        n_vec++;
        if (o.f !== f) begin n_bad++; $display("FAIL wr_fields: got %h want %h", o.f, f); end
        n_vec++;
        if (o.ack !== ea) begin n_bad++; $display("FAIL wr_ack: got %b want %b", o.ack, ea); end
        n_vec++;
        if (o.ack_n !== 8'd3) begin n_bad++; $display("FAIL wr_ack_latency: got %0d want 3", o.ack_n); end
        n_vec++;
        if (o.rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rdata: got %h want deadbeef", o.rdata); end
    endtask

    task automatic test_read_wait();
        obs_t o; fld_t f; int g; logic [N-1:0] ea;
        req_addr[AW +: AW] = 16'h0004;
        req_write[1]       = 1'b0;
        req_valid          = 3'b010;
        g = model_pick(req_valid); f = model_fields(g); ea = N'(1) << g;
        run_xfer(3, 32'h1234_5678, 1'b0, 1'b0, o);
        req_valid = '0; m_last = g;
        n_vec++;
        if (o.proto !== 1'b1) begin n_bad++; $display("FAIL rd_protocol: got %b want 1", o.proto); end
        n_vec++;
        if (o.stable !== 1'b1) begin n_bad++; $display("FAIL rd_stable: got %b want 1", o.stable); end
        n_vec++;
        if (o.f !== f) begin n_bad++; $display("FAIL rd_fields: got %h want %h", o.f, f); end
        n_vec++;
        if ({o.ack, o.rdata, o.err} !== {ea, 32'h1234_5678, 1'b0}) begin
            n_bad++; $display("FAIL rd_resp: got %b/%h/%b want %b/12345678/0", o.ack, o.rdata, o.err, ea);
        end
        n_vec++;
        if (o.cycles !== 8'd7) begin n_bad++; $display("FAIL rd_cycles: got %0d want 7", o.cycles); end
    endtask

    task automatic test_slverr();
        obs_t o; fld_t f; int g; logic [N-1:0] ea;
        req_write[2] = 1'b1;
        req_valid    = 3'b100;
        g = model_pick(req_valid); f = model_fields(g); ea = N'(1) << g;
        run_xfer(1, 32'h0BAD_0BAD, 1'b1, 1'b0, o);
        req_valid = '0; m_last = g;
        n_vec++;
        if ({o.proto, o.f} !== {1'b1, f}) begin n_bad++; $display("FAIL err_fields: got %h want %h", o.f, f); end
        n_vec++;
        if ({o.ack, o.err} !== {ea, 1'b1}) begin
            n_bad++; $display("FAIL err_resp: got %b/%b want %b/1", o.ack, o.err, ea);
        end
        repeat (3) @(posedge PCLK);
        #1;
        n_vec++;
        if (req_slverr !== 1'b1) begin n_bad++; $display("FAIL err_hold: got %b want 1", req_slverr); end
        req_valid = 3'b100;
        g = model_pick(req_valid); ea = N'(1) << g;
        run_xfer(0, 32'h0000_0001, 1'b0, 1'b0, o);
        req_valid = '0; m_last = g;
        n_vec++;
        if ({o.ack, o.err} !== {ea, 1'b0}) begin
            n_bad++; $display("FAIL err_clear: got %b/%b want %b/0", o.ack, o.err, ea);
        end
    endtask

    task automatic test_late_change();
        obs_t o; fld_t f; int g; logic [N-1:0] ea;
        scramble_fields();
        req_valid = 3'b001;
        g = model_pick(req_valid); f = model_fields(g); ea = N'(1) << g;
        run_xfer(2, 32'hCAFE_F00D, 1'b0, 1'b1, o);
        m_last = g;
        n_vec++;
        if ({o.proto, o.stable} !== 2'b11) begin
            n_bad++; $display("FAIL late_stable: got %b want 11", {o.proto, o.stable});
        end
        n_vec++;
        if (o.f !== f) begin n_bad++; $display("FAIL late_fields: got %h want %h", o.f, f); end
        n_vec++;
        if (o.ack !== ea) begin n_bad++; $display("FAIL late_ack: got %b want %b", o.ack, ea); end
    endtask

    task automatic test_round_robin();
        obs_t o; fld_t f; int g; logic [N-1:0] ea; logic [DW-1:0] rd; logic er;
        scramble_fields();
        req_valid = '1;
        for (int t = 0; t < 6; t++) begin
            g = model_pick(req_valid); f = model_fields(g); ea = N'(1) << g;
            rd = $urandom; er = 1'($urandom);
            run_xfer(0, rd, er, 1'b0, o);
            m_last = g;
            n_vec++;
            if ({o.proto, o.ack} !== {1'b1, ea}) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", t, o.ack, ea);
            end
            n_vec++;
            if ({o.f, o.rdata, o.err} !== {f, rd, er}) begin
                n_bad++; $display("FAIL rr_data[%0d]: got %h/%h/%b want %h/%h/%b", t, o.f, o.rdata, o.err, f, rd, er);
            end
            n_vec++;
            if (o.cycles !== 8'd4) begin n_bad++; $display("FAIL rr_cycles[%0d]: got %0d want 4", t, o.cycles); end
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        obs_t o; fld_t f; int g; int wt; logic [N-1:0] ea; logic [DW-1:0] rd; logic er;
        for (int t = 0; t < 24; t++) begin
            scramble_fields();
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            wt = $urandom_range(0, 4);
            g = model_pick(req_valid); f = model_fields(g); ea = N'(1) << g;
            rd = $urandom; er = 1'($urandom);
            run_xfer(wt, rd, er, 1'b0, o);
            req_valid = '0; m_last = g;
            n_vec++;
            if ({o.proto, o.stable, o.ack} !== {2'b11, ea}) begin
                n_bad++; $display("FAIL rand_grant[%0d]: got %b/%b/%b want 1/1/%b", t, o.proto, o.stable, o.ack, ea);
            end
            n_vec++;
            if ({o.f, o.rdata, o.err} !== {f, rd, er}) begin
                n_bad++; $display("FAIL rand_data[%0d]: got %h/%h/%b want %h/%h/%b", t, o.f, o.rdata, o.err, f, rd, er);
            end
            n_vec++;
            if (o.cycles !== 8'(4 + wt)) begin
                n_bad++; $display("FAIL rand_cycles[%0d]: got %0d want %0d", t, o.cycles, 4 + wt);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; fld_t f; int g; int n; logic [N-1:0] ea;
        scramble_fields();
        PREADY = 1'b0;
        req_valid = 3'b010;
        n = 0;
        do begin
            @(posedge PCLK); #1; n++;
        end while (!(PSEL && PENABLE) && n < 16);
        n_vec++;
        if (!(PSEL && PENABLE)) begin
            n_bad++; $display("FAIL rst_mid_access: got PSEL=%b PENABLE=%b want 1/1", PSEL, PENABLE);
        end
        @(posedge PCLK); #2;
        PRESET = 1'b1;
        #1;
        n_vec++;
        if ({PSEL, PENABLE, req_ack} !== '0) begin
            n_bad++; $display("FAIL rst_mid_async: got %b/%b/%b want 0/0/0", PSEL, PENABLE, req_ack);
        end
        PREADY = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        n_vec++;
        if (req_ack !== '0) begin n_bad++; $display("FAIL rst_mid_noack: got %b want 000", req_ack); end
        PREADY = 1'b0;
        req_valid = 3'b110;
        PRESET = 1'b0;
        m_last = N - 1;
        g = model_pick(req_valid); f = model_fields(g); ea = N'(1) << g;
        run_xfer(0, 32'h5555_AAAA, 1'b0, 1'b0, o);
        req_valid = '0; m_last = g;
        n_vec++;
        if ({o.proto, o.ack} !== {1'b1, ea}) begin
            n_bad++; $display("FAIL rst_restart_grant: got %b want %b", o.ack, ea);
        end
        n_vec++;
        if (o.f !== f) begin n_bad++; $display("FAIL rst_restart_fields: got %h want %h", o.f, f); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_slverr();
        test_late_change();
        test_round_robin();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
